// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants, state type and circular search for the round-robin arbiter
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of vec scanning start, start+1, ... with wrap at N_REQ.
    // Walks offsets from farthest to nearest so the nearest hit is written last.
    function automatic pick_t pick(input logic [N_REQ-1:0] vec, input logic [IDX_W-1:0] start);
        pick_t            r;
        logic [IDX_W-1:0] j;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = start + IDX_W'(i);
            if (vec[j]) begin
                r.found = 1'b1;
                r.idx   = j;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_decode_arbiter_dec.sv
// rtl/rr_decode_arbiter_dec.sv - 3-to-8 one-hot decoder
module rr_decode_arbiter_dec
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] in_idx,
    output logic [N_REQ-1:0] out_oh
);

    // One-hot expansion of the index
    always_comb begin
        out_oh = '0;
        out_oh[in_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - round-robin arbiter with bounded tenure and decoded one-hot grant
module rr_decode_arbiter
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant_oh,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [N_REQ-1:0] grant_oh_q, grant_oh_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [N_REQ-1:0] others;
    logic [N_REQ-1:0] cur_oh;
    logic [N_REQ-1:0] next_oh;
    pick_t            pick_req;
    pick_t            pick_oth;

    // Decoder for the current grantee, used to mask it out of the competitor set
    rr_decode_arbiter_dec u_dec_cur (
        .in_idx (grant_idx_q),
        .out_oh (cur_oh)
    );

    // Decoder on the next-state index; its output is gated and registered as grant_oh
    rr_decode_arbiter_dec u_dec_next (
        .in_idx (grant_idx_d),
        .out_oh (next_oh)
    );

    // Candidate winners: fresh search from ptr when idle, search past the grantee otherwise
    always_comb begin
        others   = req & ~cur_oh;
        pick_req = pick(req, ptr_q);
        pick_oth = pick(others, grant_idx_q + 3'd1);
    end

    // Next-state arbitration: release handoff, tenure timeout, or hold with saturating count
    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        hold_cnt_d    = hold_cnt_q;
        ptr_d         = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_req.found) begin
                    state_d       = GRANT;
                    grant_valid_d = 1'b1;
                    grant_idx_d   = pick_req.idx;
                    hold_cnt_d    = '0;
                    ptr_d         = pick_req.idx + 3'd1;
                end
            end
            GRANT: begin
                if (!req[grant_idx_q]) begin
                    if (pick_oth.found) begin
                        grant_idx_d = pick_oth.idx;
                        hold_cnt_d  = '0;
                        ptr_d       = pick_oth.idx + 3'd1;
                    end else begin
                        state_d       = IDLE;
                        grant_valid_d = 1'b0;
                        grant_idx_d   = '0;
                        hold_cnt_d    = '0;
                    end
                end else if (hold_cnt_q == HOLD_LAST && pick_oth.found) begin
                    grant_idx_d = pick_oth.idx;
                    hold_cnt_d  = '0;
                    ptr_d       = pick_oth.idx + 3'd1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
                grant_idx_d   = '0;
                hold_cnt_d    = '0;
                ptr_d         = '0;
            end
        endcase
        grant_oh_d = grant_valid_d ? next_oh : '0;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            grant_oh_q    <= '0;
            hold_cnt_q    <= '0;
            ptr_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            grant_oh_q    <= grant_oh_d;
            hold_cnt_q    <= hold_cnt_d;
            ptr_q         <= ptr_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign grant_oh    = grant_oh_q;
    assign hold_cnt    = hold_cnt_q;

endmodule
